// File: rtl/ppu_sequencer.sv
// ppu_sequencer: phase controller for one PE's post-processing unit (compute, halo exchange, drain, done).
// Build macro PPU_SEQ_RELU_EN: the drain encoder treats negative bytes as zero (fused ReLU).
//
// state        | meaning
// ST_IDLE      | waiting for start
// ST_COMPUTE   | multiplier array running, neighbour done flags latching
// ST_EXCHANGE  | halo exchange, waiting on local and all 8 neighbour done flags
// ST_DRAIN     | reading accumulator buffer, zero-run encoding into oaram
// ST_DONE      | one-cycle cycle_done pulse, then back to idle
module ppu_sequencer #(
  parameter int BANK_COUNT  = 32,
  parameter int TILE_SIZE   = 128,
  parameter int RAM_WIDTH   = 10,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          channel_group_done,
  input  logic                          exchange_done,
  input  logic [7:0]                    neighbor_exchange_done,
  output logic                          compute_active,
  output logic                          exchange_start,
  output logic [$clog2(BANK_COUNT)-1:0] buffer_bank_read,
  output logic [$clog2(TILE_SIZE)-1:0]  buffer_bank_entry,
  input  logic [7:0]                    buffer_data_read,
  output logic [7:0]                    oaram_value,
  output logic [INDEX_WIDTH-1:0]        oaram_indices_value,
  output logic [RAM_WIDTH-1:0]          oaram_address,
  output logic                          oaram_write_enable,
  output logic [RAM_WIDTH:0]            oaram_count,
  output logic                          overflow,
  output logic                          busy,
  output logic                          cycle_done
);

  localparam int BW = $clog2(BANK_COUNT);
  localparam int EW = $clog2(TILE_SIZE);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_COMPUTE  = 3'd1;
  localparam logic [2:0] ST_EXCHANGE = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  localparam logic [BW-1:0]          LAST_BANK   = BW'(BANK_COUNT - 1);
  localparam logic [EW-1:0]          LAST_ENTRY  = EW'(TILE_SIZE - 1);
  localparam logic [INDEX_WIDTH-1:0] MAXRUN      = '1;
  localparam logic [RAM_WIDTH:0]     OARAM_DEPTH = {1'b1, {RAM_WIDTH{1'b0}}};

  logic [2:0]             state;
  logic [7:0]             nbr_done;
  logic                   rd_active;
  logic                   rd_valid;
  logic                   rd_last;
  logic                   enc_valid;
  logic                   enc_last;
  logic [7:0]             data_q;
  logic [INDEX_WIDTH-1:0] run;

  logic [7:0] enc_byte;
  logic       nbr_all;
  logic       rd_is_last;
  logic       enc_write;
  logic       oaram_full;

  always_comb begin
    enc_byte = data_q;
`ifdef PPU_SEQ_RELU_EN
    if (data_q[7]) enc_byte = 8'd0;
`endif
    nbr_all    = &(nbr_done | neighbor_exchange_done);
    rd_is_last = (buffer_bank_read == LAST_BANK) && (buffer_bank_entry == LAST_ENTRY);
    enc_write  = enc_valid && ((enc_byte != 8'd0) || (run == MAXRUN));
    oaram_full = (oaram_count == OARAM_DEPTH);
  end

  assign compute_active = (state == ST_COMPUTE);
  assign busy           = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ST_IDLE;
      nbr_done            <= '0;
      rd_active           <= 1'b0;
      rd_valid            <= 1'b0;
      rd_last             <= 1'b0;
      enc_valid           <= 1'b0;
      enc_last            <= 1'b0;
      data_q              <= '0;
      run                 <= '0;
      exchange_start      <= 1'b0;
      buffer_bank_read    <= '0;
      buffer_bank_entry   <= '0;
      oaram_value         <= '0;
      oaram_indices_value <= '0;
      oaram_address       <= '0;
      oaram_write_enable  <= 1'b0;
      oaram_count         <= '0;
      overflow            <= 1'b0;
      cycle_done          <= 1'b0;
    end else begin
      exchange_start     <= 1'b0;
      cycle_done         <= 1'b0;
      oaram_write_enable <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_COMPUTE;
            nbr_done    <= '0;
            oaram_count <= '0;
            overflow    <= 1'b0;
            run         <= '0;
          end
        end
        ST_COMPUTE: begin
          nbr_done <= nbr_done | neighbor_exchange_done;
          if (channel_group_done) begin
            state          <= ST_EXCHANGE;
            exchange_start <= 1'b1;
          end
        end
        ST_EXCHANGE: begin
          nbr_done <= nbr_done | neighbor_exchange_done;
          if (exchange_done && nbr_all) begin
            state             <= ST_DRAIN;
            buffer_bank_read  <= '0;
            buffer_bank_entry <= '0;
            rd_active         <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (enc_valid && enc_last) begin
            state      <= ST_DONE;
            cycle_done <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Read address walk: entries within a bank, then the next bank.
      if (rd_active) begin
        if (rd_is_last) begin
          rd_active <= 1'b0;
        end else if (buffer_bank_entry == LAST_ENTRY) begin
          buffer_bank_entry <= '0;
          buffer_bank_read  <= buffer_bank_read + BW'(1);
        end else begin
          buffer_bank_entry <= buffer_bank_entry + EW'(1);
        end
      end

      // Two-stage pipe: RAM read latency, then the registered data byte.
      rd_valid  <= rd_active;
      rd_last   <= rd_active && rd_is_last;
      data_q    <= buffer_data_read;
      enc_valid <= rd_valid;
      enc_last  <= rd_last;

      if (enc_valid) begin
        if (enc_write) begin
          run <= '0;
          if (oaram_full) begin
            overflow <= 1'b1;
          end else begin
            oaram_write_enable  <= 1'b1;
            oaram_value         <= enc_byte;
            oaram_indices_value <= run;
            oaram_address       <= oaram_count[RAM_WIDTH-1:0];
            oaram_count         <= oaram_count + (RAM_WIDTH+1)'(1);
          end
        end else begin
          run <= run + INDEX_WIDTH'(1);
        end
      end
    end
  end

endmodule
